// File: rtl/c432_key_loader_if.sv
// Key-provisioning bus between a serial key source and the c432 key loader.
// The master shifts frames in; the slave (the loader) drives the committed key and status.
interface c432_key_loader_if #(
    parameter int KEY_W = 14
);
    logic             key_start;
    logic             key_sdv;
    logic             key_sdi;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_busy;
    logic             key_done;
    logic             key_err;
    logic             locked_out;
    logic [1:0]       fail_cnt;

    // Serial side is valid-only: a bit is taken on every rising edge with key_sdv=1
    // while a frame is open; there is no ready, so a source must never assume back-pressure.
    modport master (
        output key_start, key_sdv, key_sdi,
        input  key_out, key_valid, key_busy, key_done, key_err, locked_out, fail_cnt
    );

    modport slave (
        input  key_start, key_sdv, key_sdi,
        output key_out, key_valid, key_busy, key_done, key_err, locked_out, fail_cnt
    );
endinterface

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432: shifts in key+checksum, verifies an XOR-fold,
// and commits the key atomically; repeated failures latch a lockout until reset.
module c432_key_loader #(
    parameter int KEY_W    = 14,
    parameter int CHK_W    = 4,
    parameter int MAX_FAIL = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    c432_key_loader_if.slave    key,
    output logic [1:0]          state_dbg
);
    localparam int FRAME_W = KEY_W + CHK_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int PAD_W   = ((KEY_W + 3) / 4) * 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, locked_q;
    logic [1:0]         fail_q, fail_d;
    logic [1:0]         fail_inc;
    logic               chk_match, lock_hit;

    // Zero-pad the key to whole nibbles and XOR them together.
    function automatic logic [3:0] fold(input logic [KEY_W-1:0] k);
        logic [PAD_W-1:0] p;
        logic [3:0]       acc;
        p   = PAD_W'(k);
        acc = 4'h0;
        for (int i = 0; i < PAD_W / 4; i++) acc = acc ^ p[i*4 +: 4];
        return acc;
    endfunction

    assign chk_match = (fold(shadow_q[KEY_W-1:0]) == shadow_q[FRAME_W-1:KEY_W]);
    assign fail_inc  = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
    assign lock_hit  = (int'(fail_inc) >= MAX_FAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= (state_d == SHIFT) || (state_d == CHECK);
            locked_q <= (state_d == LOCKOUT);
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key.key_start) state_d = SHIFT;
            SHIFT:   if (!key.key_start && key.key_sdv && cnt_q == LAST_BIT) state_d = CHECK;
            CHECK:   state_d = (!chk_match && lock_hit) ? LOCKOUT : IDLE;
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    // Shadow shifts LSB first, so the first bit received lands in bit 0 once full.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        valid_d  = valid_q;
        fail_d   = fail_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key.key_start) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                if (key.key_start) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (key.key_sdv) begin
                    shadow_d = {key.key_sdi, shadow_q[FRAME_W-1:1]};
                    cnt_d    = (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (chk_match) begin
                    key_d   = shadow_q[KEY_W-1:0];
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    fail_d  = 2'd0;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
                    if (lock_hit) begin
                        key_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign key.key_out    = key_q;
    assign key.key_valid  = valid_q;
    assign key.key_busy   = busy_q;
    assign key.key_done   = done_q;
    assign key.key_err    = err_q;
    assign key.locked_out = locked_q;
    assign key.fail_cnt   = fail_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader: good, stalled, bad, lockout, abort and reset frames.
module tb_c432_key_loader;
    logic        clk;
    logic        rst_n;
    logic [1:0]  state_dbg;
    int          cyc;
    int          n_vec;
    int          n_err;
    int          t0;
    int          t_hit;
    logic        got_done;
    logic        got_err;

    c432_key_loader_if #(.KEY_W(14)) bus ();

    c432_key_loader #(.KEY_W(14), .CHK_W(4), .MAX_FAIL(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.key_start = 1'b0;
        bus.key_sdv   = 1'b0;
        bus.key_sdi   = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Start pulse carries a junk sdv bit that must be discarded; alt inserts a stall before every bit but the first.
    task automatic send_frame(input logic [13:0] k, input logic [3:0] c, input bit alt,
                              output int start_cyc);
        logic [17:0] frame;
        frame = {c, k};
        tick();
        bus.key_start = 1'b1;
        bus.key_sdv   = 1'b1;
        bus.key_sdi   = 1'b1;
        start_cyc     = cyc;
        tick();
        bus.key_start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (alt && i > 0) begin
                bus.key_sdv = 1'b0;
                bus.key_sdi = 1'b1;
                tick();
            end
            bus.key_sdv = 1'b1;
            bus.key_sdi = frame[i];
            tick();
        end
        bus.key_sdv = 1'b0;
        bus.key_sdi = 1'b0;
    endtask

    task automatic wait_result(input int budget, output logic d, output logic e, output int at);
        int n;
        d  = 1'b0;
        e  = 1'b0;
        at = -1;
        n  = 0;
        while (n < budget && !d && !e) begin
            @(negedge clk);
            if (bus.key_done || bus.key_err) begin
                d  = bus.key_done;
                e  = bus.key_err;
                at = cyc;
            end
            n++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.key_start = 1'b0;
        bus.key_sdv   = 1'b0;
        bus.key_sdi   = 1'b0;
        rst_n         = 1'b0;
        #2;

        // Reset state
        check("rst_key_out", 32'(bus.key_out), 32'h0);
        check("rst_valid", 32'(bus.key_valid), 32'h0);
        check("rst_busy", 32'(bus.key_busy), 32'h0);
        check("rst_done", 32'(bus.key_done), 32'h0);
        check("rst_err", 32'(bus.key_err), 32'h0);
        check("rst_locked", 32'(bus.locked_out), 32'h0);
        check("rst_fail", 32'(bus.fail_cnt), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        tick();
        rst_n = 1'b1;

        // Good frame: 2A5C folds to C^5^A^2 = 1
        send_frame(14'h2A5C, 4'h1, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("good_done", 32'(got_done), 32'h1);
        check("good_latency", 32'(t_hit - t0), 32'd20);
        check("good_key", 32'(bus.key_out), 32'h2A5C);
        check("good_p1_p4", 32'(bus.key_out[3:0]), 32'hC);
        check("good_x1_x10", 32'(bus.key_out[13:4]), 32'h2A5);
        check("good_valid", 32'(bus.key_valid), 32'h1);
        check("good_fail", 32'(bus.fail_cnt), 32'h0);
        @(negedge clk);
        check("good_done_width", 32'(bus.key_done), 32'h0);
        check("good_busy_after", 32'(bus.key_busy), 32'h0);

        // Stalled frame: 17 stall cycles
        send_frame(14'h2A5C, 4'h1, 1'b1, t0);
        wait_result(80, got_done, got_err, t_hit);
        check("stall_done", 32'(got_done), 32'h1);
        check("stall_latency", 32'(t_hit - t0), 32'd37);
        check("stall_key", 32'(bus.key_out), 32'h2A5C);

        // Bad re-provision: 0001 needs checksum 1
        send_frame(14'h0001, 4'h0, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("reprov_err", 32'(got_err), 32'h1);
        check("reprov_no_done", 32'(got_done), 32'h0);
        check("reprov_key_kept", 32'(bus.key_out), 32'h2A5C);
        check("reprov_valid", 32'(bus.key_valid), 32'h1);
        check("reprov_fail", 32'(bus.fail_cnt), 32'h1);
        @(negedge clk);
        check("reprov_err_width", 32'(bus.key_err), 32'h0);

        send_frame(14'h2A5C, 4'h0, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("bad2_err", 32'(got_err), 32'h1);
        check("bad2_fail", 32'(bus.fail_cnt), 32'h2);
        check("bad2_valid", 32'(bus.key_valid), 32'h1);
        check("bad2_locked", 32'(bus.locked_out), 32'h0);

        // Third consecutive failure locks out and clears the key
        send_frame(14'h2A5C, 4'h0, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("bad3_err", 32'(got_err), 32'h1);
        check("lock_locked", 32'(bus.locked_out), 32'h1);
        check("lock_key", 32'(bus.key_out), 32'h0);
        check("lock_valid", 32'(bus.key_valid), 32'h0);
        check("lock_fail", 32'(bus.fail_cnt), 32'h3);
        check("lock_state", 32'(state_dbg), 32'h3);

        send_frame(14'h2A5C, 4'h1, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("lock_ignore_done", 32'(got_done), 32'h0);
        check("lock_ignore_key", 32'(bus.key_out), 32'h0);
        check("lock_ignore_busy", 32'(bus.key_busy), 32'h0);

        // Asynchronous reset out of lockout, no clock edge in between
        tick();
        rst_n = 1'b0;
        #2;
        check("arst_locked", 32'(bus.locked_out), 32'h0);
        check("arst_fail", 32'(bus.fail_cnt), 32'h0);
        check("arst_state", 32'(state_dbg), 32'h0);
        tick();
        rst_n = 1'b1;
        send_frame(14'h2A5C, 4'h1, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("unlock_done", 32'(got_done), 32'h1);
        check("unlock_key", 32'(bus.key_out), 32'h2A5C);

        // Bad checksum from a clean reset
        do_reset();
        send_frame(14'h2A5C, 4'h0, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("badclean_err", 32'(got_err), 32'h1);
        check("badclean_fail", 32'(bus.fail_cnt), 32'h1);
        check("badclean_valid", 32'(bus.key_valid), 32'h0);
        check("badclean_key", 32'(bus.key_out), 32'h0);

        // Abort after 7 bits, then a full good frame
        do_reset();
        tick();
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.key_sdv = 1'b1;
            bus.key_sdi = 1'b1;
            tick();
        end
        bus.key_sdv = 1'b0;
        send_frame(14'h2A5C, 4'h1, 1'b0, t0);
        wait_result(40, got_done, got_err, t_hit);
        check("abort_done", 32'(got_done), 32'h1);
        check("abort_latency", 32'(t_hit - t0), 32'd20);
        check("abort_key", 32'(bus.key_out), 32'h2A5C);

        // Mid-frame reset after 10 bits
        tick();
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.key_sdv = 1'b1;
            bus.key_sdi = 1'(i & 1);
            tick();
        end
        check("mid_busy", 32'(bus.key_busy), 32'h1);
        check("mid_state", 32'(state_dbg), 32'h1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_key", 32'(bus.key_out), 32'h0);
        check("mid_rst_valid", 32'(bus.key_valid), 32'h0);
        check("mid_rst_busy", 32'(bus.key_busy), 32'h0);
        check("mid_rst_state", 32'(state_dbg), 32'h0);
        bus.key_sdv = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
